fir_axil_reg_slave: RTL and testbench
=====================================

Name: fir_axil_reg_slave

Overview:
- AXI4-Lite responder (slave) register bank for the FIR filter control path; the other end of the S00_AXI master traffic.
- Accepts single-beat AXI4-Lite writes and reads, stores NUM_REGS 32-bit registers, and drives them flattened to the FIR datapath.
- Emits a one-cycle strobe per register write so the filter can reload coefficients and control.

Parameters:
- NUM_REGS, 4, number of 32-bit registers (word-addressed, byte offset 4*i).
- ADDR_W, 4, AXI address width; must satisfy 2^(ADDR_W-2) >= NUM_REGS.

Ports:
- ACLK  in  1  system clock, all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  ADDR_W  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  ADDR_W  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- regs_o  out  32*NUM_REGS  register contents; reg i at [32*i+31:32*i].
- wr_stb_o  out  NUM_REGS  one-cycle pulse on the cycle after reg i is updated.

Behaviour:
- Reset (async assert, sync release): all outputs 0, all registers 0, AW/W holding buffers empty.
- Word index = ADDR[ADDR_W-1:2]; ADDR[1:0] ignored. In range iff index < NUM_REGS.
- Write path: AW and W are captured independently into one-entry holding buffers.
- AWREADY = ~aw_full; WREADY = ~w_full. Both go 1 on the first edge after reset release.
- AW and W may arrive in either order or in the same cycle.
- Commit edge: both buffers full and BVALID = 0. On this edge:
  - the addressed register is updated byte-wise per WSTRB (WSTRB = 0 leaves it unchanged);
  - both buffers empty;
  - BVALID = 1, BRESP = OKAY (2'b00);
  - wr_stb_o[index] pulses for exactly the following cycle.
- BVALID holds until BVALID & BREADY. No new commit occurs while BVALID = 1, so a second AW/W pair waits in the buffers (backpressure via READY low).
- Read path, states R_IDLE / R_RESP:
  - R_IDLE: ARREADY = 1. On ARVALID, register RDATA from the addressed register, RRESP = OKAY, set RVALID, go to R_RESP.
  - R_RESP: ARREADY = 0. RDATA and RRESP stay stable. On RREADY, clear RVALID and return to R_IDLE; ARREADY = 1 next cycle.
  - Throughput: one read per 2 cycles minimum.
- Same-edge write commit and AR acceptance to the same register: read returns the pre-write value.
- Out-of-range access without the optional feature:
  - write is dropped, BRESP = OKAY, no wr_stb_o pulse;
  - read returns RDATA = 0, RRESP = OKAY.
- Reset asserted mid-transaction: all pending buffers and responses are discarded immediately, registers return to 0, and no B or R response is issued for them.
- Write and read paths are fully independent and may be active concurrently.

Optional Feature:
- Macro: FIR_AXIL_SLVERR_EN.
- Defined: out-of-range write returns BRESP = SLVERR (2'b10); out-of-range read returns RRESP = SLVERR with RDATA = 0. Write is still dropped, no strobe.
- Undefined: all responses OKAY, as in Behaviour.

Test Plan:
- Reset, then 4 sequential writes 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then 4 reads of the same addresses -> reads return 1, 2, 3, 4 with RRESP = 0; wr_stb_o pulses 0001, 0010, 0100, 1000 in order.
- W presented 3 cycles before AW (addr 0x8, data 0xA5A5A5A5) -> exactly one BVALID after AW accepted; regs_o[95:64] = 0xA5A5A5A5.
- Hold BREADY = 0 for 5 cycles after a write, then offer a second AW/W -> AWREADY and WREADY stay 0 after the buffers fill; second write commits only after B handshake.
- Write 0xFFFFFFFF to 0x4, then write 0x12345678 with WSTRB = 4'b0101 -> reg1 = 0xFF34FF78.
- Access addr 0x10 with NUM_REGS = 4 -> registers unchanged, read data 0; responses 2'b10 with FIR_AXIL_SLVERR_EN defined, 2'b00 without.
- Drop ARESETN while RVALID = 1 and RREADY = 0 -> RVALID = 0 immediately, all regs_o = 0; post-reset read of 0x0 returns 0.

Source files
------------

// File: rtl/fir_axil_reg_slave.sv
// AXI4-Lite register bank for the FIR control path: NUM_REGS 32-bit registers,
// flattened to the datapath with a per-register write strobe. Define
// FIR_AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module fir_axil_reg_slave #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
  input  logic [2:0]               S_AXI_ARPROT,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_stb_o
);

  localparam int IDX_W = ADDR_W - 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef FIR_AXIL_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = RESP_OKAY;
`endif

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  // Held low through reset so every READY stays 0 until the first edge after release.
  logic              ready_en_q, ready_en_d;

  logic              aw_full_q, aw_full_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic              w_full_q, w_full_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;

  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;

  logic [31:0]       regs_q [NUM_REGS];
  logic [31:0]       regs_d [NUM_REGS];

  logic [0:0]        r_state_q, r_state_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic              commit;
  logic [IDX_W-1:0]  ar_idx;

  assign S_AXI_AWREADY = ready_en_q & ~aw_full_q;
  assign S_AXI_WREADY  = ready_en_q & ~w_full_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ready_en_q & (r_state_q == R_IDLE);
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_stb_o      = wr_stb_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[32*g +: 32] = regs_q[g];
  end

  assign commit = aw_full_q & w_full_q & ~bvalid_q;
  assign ar_idx = S_AXI_ARADDR[ADDR_W-1:2];

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write path: independent AW/W holding buffers, commit when both are full and B is free.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    ready_en_d = 1'b1;
    aw_full_d  = aw_full_q;
    aw_idx_d   = aw_idx_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_stb_d   = '0;
    regs_d     = regs_q;

    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
      aw_full_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[ADDR_W-1:2];
    end
    if (S_AXI_WVALID && S_AXI_WREADY) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OOR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (32'(aw_idx_q) == i) begin
          bresp_d     = RESP_OKAY;
          wr_stb_d[i] = 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (w_strb_q[b]) regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
          end
        end
      end
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  // Read path: reads regs_q, so a same-edge commit is not visible to this read.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (r_state_q)
      R_IDLE: begin
        if (ready_en_q && S_AXI_ARVALID) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rdata_d   = '0;
          rresp_d   = RESP_OOR;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(ar_idx) == i) begin
              rdata_d = regs_q[i];
              rresp_d = RESP_OKAY;
            end
          end
        end
      end
      default: begin
        if (S_AXI_RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
    endcase
  end

  // NOTE: non-blocking assignments only here, so every flop samples the pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en_q <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_stb_q   <= '0;
      r_state_q  <= R_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      // NOTE: the register array is reset because the datapath consumes it directly.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      ready_en_q <= ready_en_d;
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_stb_q   <= wr_stb_d;
      r_state_q  <= r_state_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_fir_axil_reg_slave.sv
// Directed plus randomized bench for fir_axil_reg_slave, checked against an
// array-based register model with byte-mask merge arithmetic.
module tb_fir_axil_reg_slave;

  localparam int NR = 4;
  localparam int AW = 5;

`ifdef FIR_AXIL_SLVERR_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic [2:0]    awprot = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic [2:0]    arprot = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [32*NR-1:0] regs;
  logic [NR-1:0] wr_stb;

  fir_axil_reg_slave #(.NUM_REGS(NR), .ADDR_W(AW)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .regs_o(regs), .wr_stb_o(wr_stb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NR];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  // Reference behaviour of one write: byte-masked merge into the addressed word, if it exists.
  task automatic model_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] exp_resp, output logic [3:0] exp_stb);
    int idx;
    logic [31:0] mask;
    idx = int'(addr) / 4;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
    if (idx < NR) begin
      model[idx] = (model[idx] & ~mask) | (data & mask);
      exp_resp = 2'b00;
      exp_stb  = 4'(1 << idx);
    end else begin
      exp_resp = EXP_OOR;
      exp_stb  = 4'b0;
    end
  endtask

  task automatic model_read(input logic [AW-1:0] addr, output logic [31:0] exp_data, output logic [1:0] exp_resp);
    int idx;
    idx = int'(addr) / 4;
    if (idx < NR) begin
      exp_data = model[idx];
      exp_resp = 2'b00;
    end else begin
      exp_data = 32'h0;
      exp_resp = EXP_OOR;
    end
  endtask

  // One write with AW/W offset by independent delays; BREADY held high throughout.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output logic [3:0] stb, output logic [3:0] stb_after,
                           output int b_cnt);
    bit aw_done, w_done, aw_hs, w_hs, got;
    aw_done = 0; w_done = 0; got = 0; b_cnt = 0;
    resp = 2'bxx; stb = 4'bx; stb_after = 4'bx;
    bready = 1'b1;
    for (int c = 0; c < 100 && !(aw_done && w_done); c++) begin
      awvalid = (c >= aw_dly) && !aw_done;
      awaddr  = addr;
      wvalid  = (c >= w_dly) && !w_done;
      wdata   = data;
      wstrb   = strb;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_cnt += int'(bvalid);
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      if (bvalid) begin
        got = 1;
        resp = bresp;
        stb  = wr_stb;
      end
      b_cnt += int'(bvalid);
      tick();
    end
    stb_after = wr_stb;
    b_cnt += int'(bvalid);
    chk("b_handshake_seen", {127'b0, got}, 128'd1);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs, got;
    hs = 0; got = 0;
    data = 32'bx; resp = 2'bxx;
    arvalid = 1'b1;
    araddr  = addr;
    rready  = 1'b1;
    for (int c = 0; c < 50 && !hs; c++) begin
      hs = arready;
      tick();
    end
    arvalid = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      if (rvalid) begin
        got = 1;
        data = rdata;
        resp = rresp;
      end
      tick();
    end
    chk("r_handshake_seen", {127'b0, got}, 128'd1);
  endtask

  initial begin
    logic [1:0]  resp, exp_resp;
    logic [3:0]  stb, stb_after, exp_stb;
    logic [31:0] data, exp_data;
    logic [31:0] reg1_before;
    int b_cnt;

    for (int i = 0; i < NR; i++) model[i] = 32'h0;

    // Reset state
    repeat (3) tick();
    chk("rst_awready", {127'b0, awready}, 128'd0);
    chk("rst_wready",  {127'b0, wready},  128'd0);
    chk("rst_arready", {127'b0, arready}, 128'd0);
    chk("rst_bvalid",  {127'b0, bvalid},  128'd0);
    chk("rst_rvalid",  {127'b0, rvalid},  128'd0);
    chk("rst_regs",    regs, 128'd0);
    chk("rst_stb",     {124'b0, wr_stb}, 128'd0);
    rst_n = 1'b1;
    chk("ready_before_first_edge", {126'b0, awready, wready}, 128'd0);
    tick();
    chk("ready_after_first_edge", {125'b0, awready, wready, arready}, 128'h7);

    // Sequential writes then reads of all registers
    for (int i = 0; i < NR; i++) begin
      axi_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, resp, stb, stb_after, b_cnt);
      model_write(AW'(4 * i), 32'(i + 1), 4'hF, exp_resp, exp_stb);
      chk($sformatf("seq_bresp_%0d", i), {126'b0, resp}, 128'd0);
      chk($sformatf("seq_stb_%0d", i), {124'b0, stb}, 128'(4'b0001 << i));
      chk($sformatf("seq_stb_after_%0d", i), {124'b0, stb_after}, 128'd0);
    end
    for (int i = 0; i < NR; i++) begin
      axi_read(AW'(4 * i), data, resp);
      chk($sformatf("seq_rdata_%0d", i), {96'b0, data}, 128'(i + 1));
      chk($sformatf("seq_rresp_%0d", i), {126'b0, resp}, 128'd0);
    end

    // W leads AW by three cycles
    axi_write(5'h08, 32'hA5A5A5A5, 4'hF, 3, 0, resp, stb, stb_after, b_cnt);
    model_write(5'h08, 32'hA5A5A5A5, 4'hF, exp_resp, exp_stb);
    chk("wlead_b_count", 128'(b_cnt), 128'd1);
    chk("wlead_reg2", {96'b0, regs[95:64]}, 128'hA5A5A5A5);
    chk("wlead_stb", {124'b0, stb}, 128'b0100);

    // B backpressure: second AW/W parks in the buffers until the first B completes
    reg1_before = model[1];
    bready = 1'b0;
    awvalid = 1'b1; awaddr = 5'h00; wvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    model_write(5'h00, 32'h0BAD_F00D, 4'hF, exp_resp, exp_stb);
    chk("bp_bvalid_set", {127'b0, bvalid}, 128'd1);
    repeat (5) tick();
    chk("bp_bvalid_held", {127'b0, bvalid}, 128'd1);
    awvalid = 1'b1; awaddr = 5'h04; wvalid = 1'b1; wdata = 32'hCAFE_0001; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("bp_ready_low", {126'b0, awready, wready}, 128'd0);
    chk("bp_reg1_unchanged", {96'b0, regs[63:32]}, {96'b0, reg1_before});
    bready = 1'b1;
    tick();
    chk("bp_b_cleared", {127'b0, bvalid}, 128'd0);
    tick();
    model_write(5'h04, 32'hCAFE_0001, 4'hF, exp_resp, exp_stb);
    chk("bp_second_bvalid", {127'b0, bvalid}, 128'd1);
    chk("bp_second_stb", {124'b0, wr_stb}, 128'b0010);
    chk("bp_regs", regs, model_flat());
    tick();

    // Byte strobes
    axi_write(5'h04, 32'hFFFFFFFF, 4'hF, 0, 0, resp, stb, stb_after, b_cnt);
    model_write(5'h04, 32'hFFFFFFFF, 4'hF, exp_resp, exp_stb);
    axi_write(5'h04, 32'h12345678, 4'b0101, 1, 0, resp, stb, stb_after, b_cnt);
    model_write(5'h04, 32'h12345678, 4'b0101, exp_resp, exp_stb);
    chk("strb_reg1", {96'b0, regs[63:32]}, 128'hFF34FF78);
    axi_write(5'h04, 32'h0, 4'b0000, 0, 0, resp, stb, stb_after, b_cnt);
    model_write(5'h04, 32'h0, 4'b0000, exp_resp, exp_stb);
    chk("strb_zero_reg1", {96'b0, regs[63:32]}, 128'hFF34FF78);

    // Out of range
    axi_write(5'h10, 32'hDEADBEEF, 4'hF, 0, 0, resp, stb, stb_after, b_cnt);
    chk("oor_bresp", {126'b0, resp}, {126'b0, EXP_OOR});
    chk("oor_stb", {124'b0, stb}, 128'd0);
    chk("oor_regs", regs, model_flat());
    axi_read(5'h10, data, resp);
    chk("oor_rdata", {96'b0, data}, 128'd0);
    chk("oor_rresp", {126'b0, resp}, {126'b0, EXP_OOR});

    // Randomized writes and reads against the model
    for (int n = 0; n < 30; n++) begin
      logic [AW-1:0] a;
      logic [31:0]   d;
      logic [3:0]    s;
      a = {3'($urandom_range(0, 7)), 2'($urandom)};
      d = $urandom;
      s = 4'($urandom);
      axi_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp, stb, stb_after, b_cnt);
      model_write(a, d, s, exp_resp, exp_stb);
      chk($sformatf("rnd_bresp_%0d", n), {126'b0, resp}, {126'b0, exp_resp});
      chk($sformatf("rnd_stb_%0d", n), {124'b0, stb}, {124'b0, exp_stb});
      chk($sformatf("rnd_regs_%0d", n), regs, model_flat());
      a = {3'($urandom_range(0, 7)), 2'($urandom)};
      axi_read(a, data, resp);
      model_read(a, exp_data, exp_resp);
      chk($sformatf("rnd_rdata_%0d", n), {96'b0, data}, {96'b0, exp_data});
      chk($sformatf("rnd_rresp_%0d", n), {126'b0, resp}, {126'b0, exp_resp});
    end

    // Reset while a read response is stalled
    rready = 1'b0;
    arvalid = 1'b1; araddr = 5'h08;
    tick();
    arvalid = 1'b0;
    tick();
    chk("mid_rvalid_pending", {127'b0, rvalid}, 128'd1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    chk("mid_rvalid_cleared", {127'b0, rvalid}, 128'd0);
    chk("mid_regs_cleared", regs, 128'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    axi_read(5'h00, data, resp);
    chk("post_rst_rdata", {96'b0, data}, 128'd0);
    chk("post_rst_rresp", {126'b0, resp}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
